// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, with registered grant,
// lock-aware tenure, and a watchdog that forces an error on a stalled slave.
module wishbone_rr_arbiter #(
    parameter int unsigned NUM_MASTERS   = 4,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SELECT_WIDTH  = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_cycle,
    input  logic [NUM_MASTERS-1:0]                m_strobe,
    input  logic [NUM_MASTERS-1:0]                m_writeEnable,
    input  logic [NUM_MASTERS-1:0]                m_lock,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]  m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dataMaster,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]   m_select,
    output logic [NUM_MASTERS-1:0]                m_ack,
    output logic [NUM_MASTERS-1:0]                m_error,
    output logic [NUM_MASTERS-1:0]                m_retry,
    output logic [DATA_WIDTH-1:0]                 m_dataSlave,
    output logic                                  s_cycle,
    output logic                                  s_strobe,
    output logic                                  s_writeEnable,
    output logic                                  s_lock,
    output logic [ADDRESS_WIDTH-1:0]              s_address,
    output logic [DATA_WIDTH-1:0]                 s_dataMaster,
    output logic [SELECT_WIDTH-1:0]               s_select,
    input  logic                                  s_ack,
    input  logic                                  s_error,
    input  logic                                  s_retry,
    input  logic [DATA_WIDTH-1:0]                 s_dataSlave,
    output logic [NUM_MASTERS-1:0]                grant
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : gen_bad_num_masters
        $error("wishbone_rr_arbiter: NUM_MASTERS must be in 2..8");
    end

    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WdW  = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WdW-1:0]  TimeoutCnt = WdW'(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [WdW-1:0]         wd_q, wd_d;

    logic                     sel_cyc, sel_stb, sel_we, sel_lock;
    logic [ADDRESS_WIDTH-1:0] sel_adr;
    logic [DATA_WIDTH-1:0]    sel_dat;
    logic [SELECT_WIDTH-1:0]  sel_sel;
    logic                     owned, term, expire;

    // AND-OR mux on the one-hot grant; all zero while idle.
    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_lock = 1'b0;
        sel_adr  = '0;
        sel_dat  = '0;
        sel_sel  = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant_q[i]) begin
                sel_cyc  = m_cycle[i];
                sel_stb  = m_strobe[i];
                sel_we   = m_writeEnable[i];
                sel_lock = m_lock[i];
                sel_adr  = m_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_dat  = m_dataMaster[i*DATA_WIDTH +: DATA_WIDTH];
                sel_sel  = m_select[i*SELECT_WIDTH +: SELECT_WIDTH];
            end
        end
    end

    assign owned  = (state_q == StOwned);
    assign term   = s_ack | s_error | s_retry;
    // A coincident slave termination wins over the watchdog.
    assign expire = (TIMEOUT != 0) && owned && (wd_q == TimeoutCnt) && !term;

    assign s_cycle       = owned & sel_cyc & ~expire;
    assign s_strobe      = owned & sel_stb & ~expire;
    assign s_writeEnable = owned & sel_we;
    assign s_lock        = owned & sel_lock;
    assign s_address     = owned ? sel_adr : '0;
    assign s_dataMaster  = owned ? sel_dat : '0;
    assign s_select      = owned ? sel_sel : '0;

    assign m_ack       = s_ack ? grant_q : '0;
    assign m_error     = (s_error || expire) ? grant_q : '0;
    assign m_retry     = s_retry ? grant_q : '0;
    assign m_dataSlave = s_dataSlave;
    assign grant       = grant_q;

    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wd_d    = '0;
        found   = 1'b0;
        idx     = '0;
        unique case (state_q)
            StIdle: begin
                for (int k = 0; k < int'(NUM_MASTERS); k++) begin
                    idx = IdxW'((int'(ptr_q) + k) % int'(NUM_MASTERS));
                    if (!found && m_cycle[idx]) begin
                        found   = 1'b1;
                        state_d = StOwned;
                        owner_d = idx;
                        grant_d = NUM_MASTERS'(1) << idx;
                    end
                end
            end
            StOwned: begin
                if (expire || (!sel_cyc && !sel_lock)) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
                end else if (TIMEOUT != 0 && sel_cyc && sel_stb && !term) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: rotation, routing, lock, watchdog and reset.
module tb_wishbone_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    m_cycle = '0, m_strobe = '0, m_writeEnable = '0, m_lock = '0;
    logic [N*AW-1:0] m_address = '0;
    logic [N*DW-1:0] m_dataMaster = '0;
    logic [N*SW-1:0] m_select = '0;
    logic [N-1:0]    m_ack, m_error, m_retry, grant;
    logic [DW-1:0]   m_dataSlave;
    logic            s_cycle, s_strobe, s_writeEnable, s_lock;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_dataMaster;
    logic [SW-1:0]   s_select;
    logic            s_ack = 1'b0, s_error = 1'b0, s_retry = 1'b0;
    logic [DW-1:0]   s_dataSlave = '0;

    int n_checks = 0;
    int n_fail   = 0;

    wishbone_rr_arbiter #(
        .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .TIMEOUT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .m_cycle(m_cycle), .m_strobe(m_strobe), .m_writeEnable(m_writeEnable),
        .m_lock(m_lock), .m_address(m_address), .m_dataMaster(m_dataMaster),
        .m_select(m_select), .m_ack(m_ack), .m_error(m_error), .m_retry(m_retry),
        .m_dataSlave(m_dataSlave), .s_cycle(s_cycle), .s_strobe(s_strobe),
        .s_writeEnable(s_writeEnable), .s_lock(s_lock), .s_address(s_address),
        .s_dataMaster(s_dataMaster), .s_select(s_select), .s_ack(s_ack),
        .s_error(s_error), .s_retry(s_retry), .s_dataSlave(s_dataSlave), .grant(grant)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        m_cycle = 4'b1111;
        m_strobe = 4'b1111;
        #3;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant);
        end
        n_checks++;
        if ({s_cycle, s_strobe, s_writeEnable, s_lock} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_sctl got=%b exp=0000",
                               {s_cycle, s_strobe, s_writeEnable, s_lock});
        end
        n_checks++;
        step();
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant_clocked got=%b exp=0000", grant);
        end
        n_checks++;
        m_cycle = '0;
        m_strobe = '0;
        reset = 1'b1;
        step();
    endtask

    // All four request continuously; each tenure ends by dropping the owner's cycle.
    task automatic test_rotation();
        int exp_owner [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_g;
        m_cycle = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            step();
            exp_g = 4'b0001 << exp_owner[t];
            if (grant !== exp_g) begin
                n_fail++; $display("FAIL rotation_grant[%0d] got=%b exp=%b", t, grant, exp_g);
            end
            n_checks++;
            if (s_cycle !== 1'b1) begin
                n_fail++; $display("FAIL rotation_scyc[%0d] got=%b exp=1", t, s_cycle);
            end
            n_checks++;
            m_cycle = 4'b1111 & ~exp_g;
            step();
            if (grant !== 4'b0000 || s_cycle !== 1'b0) begin
                n_fail++; $display("FAIL rotation_idle[%0d] got=%b/%b exp=0000/0",
                                   t, grant, s_cycle);
            end
            n_checks++;
            m_cycle = (t == 4) ? 4'b0000 : 4'b1111;
        end
    endtask

    task automatic test_read_ack();
        m_cycle = 4'b0100;
        m_strobe = 4'b0100;
        m_writeEnable = 4'b0000;
        m_address[2*AW +: AW] = 32'h2000_0040;
        m_select[2*SW +: SW] = 4'hF;
        step();
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL read_grant got=%b exp=0100", grant);
        end
        n_checks++;
        if (s_address !== 32'h2000_0040 || s_strobe !== 1'b1 || s_writeEnable !== 1'b0) begin
            n_fail++; $display("FAIL read_slave_side got=%h/%b/%b exp=20000040/1/0",
                               s_address, s_strobe, s_writeEnable);
        end
        n_checks++;
        s_ack = 1'b1;
        s_dataSlave = 32'hDEAD_BEEF;
        #1;
        if (m_ack !== 4'b0100) begin
            n_fail++; $display("FAIL read_ack got=%b exp=0100", m_ack);
        end
        n_checks++;
        if (m_dataSlave !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL read_data got=%h exp=deadbeef", m_dataSlave);
        end
        n_checks++;
        step();
        s_ack = 1'b0;
        m_cycle = '0;
        m_strobe = '0;
        step();
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL read_release got=%b exp=0000", grant);
        end
        n_checks++;
    endtask

    // Pointer is 3 here; master 1 requests alone, then locks while master 3 waits.
    task automatic test_lock();
        m_cycle = 4'b0010;
        m_lock = 4'b0010;
        step();
        if (grant !== 4'b0010) begin
            n_fail++; $display("FAIL lock_grant got=%b exp=0010", grant);
        end
        n_checks++;
        s_error = 1'b1;
        #1;
        if (m_error !== 4'b0010 || m_ack !== 4'b0000 || m_retry !== 4'b0000) begin
            n_fail++; $display("FAIL lock_err_route got=%b/%b/%b exp=0010/0000/0000",
                               m_error, m_ack, m_retry);
        end
        n_checks++;
        s_error = 1'b0;
        m_cycle = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            if (grant !== 4'b0010 || s_lock !== 1'b1 || s_cycle !== 1'b0) begin
                n_fail++; $display("FAIL lock_hold[%0d] got=%b/%b/%b exp=0010/1/0",
                                   c, grant, s_lock, s_cycle);
            end
            n_checks++;
        end
        m_lock = 4'b0000;
        step();
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL lock_release got=%b exp=0000", grant);
        end
        n_checks++;
        step();
        if (grant !== 4'b1000) begin
            n_fail++; $display("FAIL lock_next got=%b exp=1000", grant);
        end
        n_checks++;
        m_cycle = '0;
        step();
    endtask

    task automatic test_timeout();
        m_cycle = 4'b0001;
        m_strobe = 4'b0001;
        m_writeEnable = 4'b0001;
        step();
        for (int c = 0; c < 4; c++) begin
            if (s_strobe !== 1'b1 || m_error !== 4'b0000) begin
                n_fail++; $display("FAIL timeout_wait[%0d] got=%b/%b exp=1/0000",
                                   c, s_strobe, m_error);
            end
            n_checks++;
            step();
        end
        if (m_error !== 4'b0001 || s_strobe !== 1'b0 || s_cycle !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fire got=%b/%b/%b exp=0001/0/0",
                               m_error, s_strobe, s_cycle);
        end
        n_checks++;
        step();
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL timeout_release got=%b exp=0000", grant);
        end
        n_checks++;
        step();
        for (int c = 0; c < 4; c++) step();
        s_ack = 1'b1;
        #1;
        if (m_ack !== 4'b0001 || m_error !== 4'b0000 || s_strobe !== 1'b1) begin
            n_fail++; $display("FAIL timeout_ack_prio got=%b/%b/%b exp=0001/0000/1",
                               m_ack, m_error, s_strobe);
        end
        n_checks++;
        step();
        s_ack = 1'b0;
        #1;
        if (grant !== 4'b0001 || m_error !== 4'b0000) begin
            n_fail++; $display("FAIL timeout_ack_keep got=%b/%b exp=0001/0000", grant, m_error);
        end
        n_checks++;
        m_cycle = '0;
        m_strobe = '0;
        step();
    endtask

    // Pointer is 1 before the reset, so master 0 winning proves the pointer was cleared.
    task automatic test_reset_midtransfer();
        m_cycle = 4'b0001;
        m_strobe = 4'b0001;
        m_writeEnable = 4'b0001;
        m_dataMaster[0 +: DW] = 32'hCAFE_0000;
        step();
        if (s_cycle !== 1'b1 || s_dataMaster !== 32'hCAFE_0000) begin
            n_fail++; $display("FAIL midreset_pre got=%b/%h exp=1/cafe0000",
                               s_cycle, s_dataMaster);
        end
        n_checks++;
        #2;
        reset = 1'b0;
        #1;
        if (s_cycle !== 1'b0 || s_strobe !== 1'b0 || grant !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_async got=%b/%b/%b exp=0/0/0000",
                               s_cycle, s_strobe, grant);
        end
        n_checks++;
        m_cycle = 4'b1001;
        m_strobe = '0;
        #3;
        reset = 1'b1;
        step();
        if (grant !== 4'b0001 || s_cycle !== 1'b1) begin
            n_fail++; $display("FAIL midreset_favour0 got=%b/%b exp=0001/1", grant, s_cycle);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_read_ack();
        test_lock();
        test_timeout();
        test_reset_midtransfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
